// File: rtl/lane_align_7l.sv
// Lane deskew buffer: one small FIFO per lane; a full word set is released
// only once every lane holds at least one word, preserving per-lane order.
module lane_align_7l #(
  parameter int DATA_WIDTH = 18,
  parameter int LANES      = 4,
  parameter int DEPTH      = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [LANES*DATA_WIDTH-1:0] lane_in,
  input  logic [LANES-1:0]            lane_valid,
  output logic [LANES*DATA_WIDTH-1:0] align_out,
  output logic                        align_valid,
  input  logic                        align_ready,
  input  logic                        err_clr,
  output logic [LANES-1:0]            ovf_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [LANES][DEPTH];
  logic [PTR_W-1:0]      wr_ptr [LANES];
  logic [PTR_W-1:0]      rd_ptr [LANES];
  logic [CNT_W-1:0]      count [LANES];

  logic [LANES-1:0] nonempty;
  logic [LANES-1:0] full;
  logic [LANES-1:0] push;
  logic [LANES-1:0] ovf;
  logic             load_en;

  // A full lane can still accept a word when the shared pop frees a slot.
  always_comb begin
    nonempty = '0;
    full     = '0;
    push     = '0;
    ovf      = '0;
    for (int i = 0; i < LANES; i++) begin
      nonempty[i] = (count[i] != '0);
      full[i]     = (count[i] == CNT_W'(DEPTH));
    end
    load_en = (&nonempty) && (!align_valid || align_ready);
    for (int i = 0; i < LANES; i++) begin
      push[i] = lane_valid[i] && (!full[i] || load_en);
      ovf[i]  = lane_valid[i] && full[i] && !load_en;
    end
  end

  // Stage p0: FIFO pointer and occupancy control
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LANES; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        if (load_en) rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
        count[i] <= count[i] + CNT_W'(push[i]) - CNT_W'(load_en);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (!reset && push[i]) mem[i][wr_ptr[i]] <= lane_in[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Stage p1: registered aligned output set
  always_ff @(posedge clk) begin
    if (reset) begin
      align_out   <= '0;
      align_valid <= 1'b0;
    end else if (load_en) begin
      for (int i = 0; i < LANES; i++) begin
        align_out[i*DATA_WIDTH +: DATA_WIDTH] <= mem[i][rd_ptr[i]];
      end
      align_valid <= 1'b1;
    end else if (align_ready) begin
      align_valid <= 1'b0;
    end
  end

  // Overflow set takes priority over a same-edge clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_err <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (ovf[i])       ovf_err[i] <= 1'b1;
        else if (err_clr) ovf_err[i] <= 1'b0;
      end
    end
  end

endmodule
